// File: rtl/operand_split_feeder.sv
// Q*K systolic front end: holds 4x4 Q/K tiles, streams skewed INT/FRAC1/FRAC2
// passes into the array, then sequences the partial-product adder controls.
module operand_split_feeder #(
  parameter int width = 8,
  parameter int DRAIN = 4
) (
  input  logic                      clk,
  input  logic                      _reset,
  input  logic                      load_valid,
  input  logic                      load_sel,
  input  logic [1:0]                load_row,
  input  logic signed [2*width-1:0] load_d0,
  input  logic signed [2*width-1:0] load_d1,
  input  logic signed [2*width-1:0] load_d2,
  input  logic signed [2*width-1:0] load_d3,
  input  logic                      start,
  output logic                      busy,
  output logic signed [width:0]     a_row0,
  output logic signed [width:0]     a_row1,
  output logic signed [width:0]     a_row2,
  output logic signed [width:0]     a_row3,
  output logic signed [width:0]     b_col0,
  output logic signed [width:0]     b_col1,
  output logic signed [width:0]     b_col2,
  output logic signed [width:0]     b_col3,
  output logic                      feed_valid,
  output logic                      array_clear,
  output logic [1:0]                pass_id,
  output logic                      add_enable,
  output logic                      add_int_flag,
  output logic                      done
);
  localparam int EW    = 2 * width;
  localparam int CNT_W = (DRAIN > 8) ? $clog2(DRAIN) : 3;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(6);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_ADD_F, S_ADD_T, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             pass_q, pass_d;
  logic [3:0][3:0][EW-1:0] q_mem_q, q_mem_d, k_mem_q, k_mem_d;
  logic [3:0][width:0]    a_q, a_d, b_q, b_d;
  logic busy_q, busy_d, feed_valid_q, feed_valid_d, array_clear_q, array_clear_d;
  logic add_enable_q, add_enable_d, add_int_flag_q, add_int_flag_d, done_q, done_d;
  logic [1:0] pass_id_q, pass_id_d;

  function automatic logic [width:0] split_part(input logic [EW-1:0] x, input logic frac);
    return frac ? {1'b0, x[width-1:0]} : {x[EW-1], x[EW-1:width]};
  endfunction

  // Tiles are frozen for the whole sequence so every pass sees the same data.
  always_comb begin
    q_mem_d = q_mem_q;
    k_mem_d = k_mem_q;
    if (load_valid && !busy_q) begin
      if (load_sel) k_mem_d[load_row] = {load_d3, load_d2, load_d1, load_d0};
      else          q_mem_d[load_row] = {load_d3, load_d2, load_d1, load_d0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE:  if (start) begin state_d = S_CLEAR; pass_d = '0; end
      S_CLEAR: begin state_d = S_FEED; cnt_d = '0; end
      S_FEED:
        if (cnt_q == FEED_LAST) begin state_d = S_DRAIN; cnt_d = '0; end
        else cnt_d = cnt_q + CNT_W'(1);
      S_DRAIN:
        if (cnt_q == DRAIN_LAST) begin
          cnt_d = '0;
          if (pass_q == 2'd2) state_d = S_ADD_F;
          else begin state_d = S_CLEAR; pass_d = pass_q + 2'd1; end
        end else cnt_d = cnt_q + CNT_W'(1);
      S_ADD_F: state_d = S_ADD_T;
      S_ADD_T: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they land in the same cycle as that state.
  always_comb begin
    int j;
    j              = 0;
    busy_d         = (state_d != S_IDLE);
    array_clear_d  = (state_d == S_CLEAR);
    feed_valid_d   = (state_d == S_FEED);
    add_enable_d   = (state_d == S_ADD_F) || (state_d == S_ADD_T);
    add_int_flag_d = (state_d == S_ADD_T);
    done_d         = (state_d == S_DONE);
    pass_id_d      = (state_d inside {S_CLEAR, S_FEED, S_DRAIN}) ? pass_d : 2'd0;
    a_d            = '0;
    b_d            = '0;
    if (state_d == S_FEED) begin
      for (int r = 0; r < 4; r++) begin
        j = int'(cnt_d) - r;
        if (j >= 0 && j <= 3) begin
          a_d[r[1:0]] = split_part(q_mem_q[r[1:0]][j[1:0]], pass_d == 2'd2);
          b_d[r[1:0]] = split_part(k_mem_q[j[1:0]][r[1:0]], pass_d == 2'd1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      q_mem_q <= '0;
      k_mem_q <= '0;
    end else begin
      q_mem_q <= q_mem_d;
      k_mem_q <= k_mem_d;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pass_q         <= '0;
      busy_q         <= 1'b0;
      array_clear_q  <= 1'b0;
      feed_valid_q   <= 1'b0;
      add_enable_q   <= 1'b0;
      add_int_flag_q <= 1'b0;
      done_q         <= 1'b0;
      pass_id_q      <= '0;
      a_q            <= '0;
      b_q            <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pass_q         <= pass_d;
      busy_q         <= busy_d;
      array_clear_q  <= array_clear_d;
      feed_valid_q   <= feed_valid_d;
      add_enable_q   <= add_enable_d;
      add_int_flag_q <= add_int_flag_d;
      done_q         <= done_d;
      pass_id_q      <= pass_id_d;
      a_q            <= a_d;
      b_q            <= b_d;
    end
  end

  assign busy         = busy_q;
  assign array_clear  = array_clear_q;
  assign feed_valid   = feed_valid_q;
  assign add_enable   = add_enable_q;
  assign add_int_flag = add_int_flag_q;
  assign done         = done_q;
  assign pass_id      = pass_id_q;
  assign a_row0 = a_q[0];
  assign a_row1 = a_q[1];
  assign a_row2 = a_q[2];
  assign a_row3 = a_q[3];
  assign b_col0 = b_q[0];
  assign b_col1 = b_q[1];
  assign b_col2 = b_q[2];
  assign b_col3 = b_q[3];
endmodule

// File: tb/tb_operand_split_feeder.sv
// Bench for operand_split_feeder: cycle-indexed reference model plus directed
// runs with hand-computed operand/control values at key cycles.
module tb_operand_split_feeder;
  localparam int DR   = 4;
  localparam int P    = 8 + DR;
  localparam int LAST = 3 * P + 3;

  logic clk, rst_n, load_valid, load_sel, start;
  logic [1:0]  load_row;
  logic [15:0] load_d0, load_d1, load_d2, load_d3;
  logic        busy, feed_valid, array_clear, add_enable, add_int_flag, done;
  logic [1:0]  pass_id;
  logic [8:0]  a_row0, a_row1, a_row2, a_row3, b_col0, b_col1, b_col2, b_col3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  operand_split_feeder #(.width(8), .DRAIN(DR)) dut (
    .clk(clk), ._reset(rst_n), .load_valid(load_valid), .load_sel(load_sel),
    .load_row(load_row), .load_d0(load_d0), .load_d1(load_d1), .load_d2(load_d2),
    .load_d3(load_d3), .start(start), .busy(busy),
    .a_row0(a_row0), .a_row1(a_row1), .a_row2(a_row2), .a_row3(a_row3),
    .b_col0(b_col0), .b_col1(b_col1), .b_col2(b_col2), .b_col3(b_col3),
    .feed_valid(feed_valid), .array_clear(array_clear), .pass_id(pass_id),
    .add_enable(add_enable), .add_int_flag(add_int_flag), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: t counts cycles since the accepting edge (0 = idle).
  int          t = 0;
  logic [15:0] mq[4][4];
  logic [15:0] mk[4][4];

  function automatic logic [8:0] int_part(input logic [15:0] x);
    int s;
    s = int'($signed(x)) >>> 8;
    return s[8:0];
  endfunction

  function automatic logic [8:0] frac_part(input logic [15:0] x);
    int s;
    s = int'(x) % 256;
    return s[8:0];
  endfunction

  initial begin
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin mq[r][c] = '0; mk[r][c] = '0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        t = 0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin mq[r][c] = '0; mk[r][c] = '0; end
      end else begin
        if (load_valid && t == 0) begin
          if (load_sel) begin
            mk[load_row][0] = load_d0; mk[load_row][1] = load_d1;
            mk[load_row][2] = load_d2; mk[load_row][3] = load_d3;
          end else begin
            mq[load_row][0] = load_d0; mq[load_row][1] = load_d1;
            mq[load_row][2] = load_d2; mq[load_row][3] = load_d3;
          end
        end
        if (t == 0)         t = start ? 1 : 0;
        else if (t == LAST) t = 0;
        else                t = t + 1;
      end
    end
  end

  initial begin
    logic [8:0] ea[4], eb[4], aa[4], ab[4];
    logic       eclr, efv, eae, eaf, edn;
    logic [1:0] epid;
    int p, off, k, j;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin ea[i] = '0; eb[i] = '0; end
      eclr = 0; efv = 0; eae = 0; eaf = 0; edn = 0; epid = 0; p = 0; off = 0; k = 0; j = 0;
      if (t >= 1 && t <= 3 * P) begin
        p = (t - 1) / P;
        off = (t - 1) % P;
        epid = 2'(p);
        if (off == 0) eclr = 1;
        else if (off <= 7) begin
          efv = 1;
          k = off - 1;
          for (int i = 0; i < 4; i++) begin
            j = k - i;
            if (j >= 0 && j <= 3) begin
              ea[i] = (p == 2) ? frac_part(mq[i][j]) : int_part(mq[i][j]);
              eb[i] = (p == 1) ? frac_part(mk[j][i]) : int_part(mk[j][i]);
            end
          end
        end
      end else if (t == 3 * P + 1) eae = 1;
      else if (t == 3 * P + 2) begin eae = 1; eaf = 1; end
      else if (t == 3 * P + 3) edn = 1;
      aa[0] = a_row0; aa[1] = a_row1; aa[2] = a_row2; aa[3] = a_row3;
      ab[0] = b_col0; ab[1] = b_col1; ab[2] = b_col2; ab[3] = b_col3;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("a_row%0d t=%0d", i, t), 32'(aa[i]), 32'(ea[i]));
        chk($sformatf("b_col%0d t=%0d", i, t), 32'(ab[i]), 32'(eb[i]));
      end
      chk("busy",         32'(busy),         32'(t != 0));
      chk("array_clear",  32'(array_clear),  32'(eclr));
      chk("feed_valid",   32'(feed_valid),   32'(efv));
      chk("pass_id",      32'(pass_id),      32'(epid));
      chk("add_enable",   32'(add_enable),   32'(eae));
      chk("add_int_flag", 32'(add_int_flag), 32'(eaf));
      chk("done",         32'(done),         32'(edn));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic adv_to(input int n);
    while (cyc < n) begin tick(); cyc++; end
  endtask

  task automatic launch(input bit hold);
    start = 1'b1;
    tick();
    cyc = 1;
    if (!hold) start = 1'b0;
  endtask

  task automatic load(input logic sel, input logic [1:0] row,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3);
    load_valid = 1'b1; load_sel = sel; load_row = row;
    load_d0 = d0; load_d1 = d1; load_d2 = d2; load_d3 = d3;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_sel = 1'b0; load_row = '0;
    load_d0 = '0; load_d1 = '0; load_d2 = '0; load_d3 = '0;
    repeat (3) tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Identity tiles scaled by 0x0100: every int part 1, every frac part 0.
    for (int r = 0; r < 4; r++) begin
      load(1'b0, 2'(r), (r == 0) ? 16'h0100 : 16'h0, (r == 1) ? 16'h0100 : 16'h0,
                        (r == 2) ? 16'h0100 : 16'h0, (r == 3) ? 16'h0100 : 16'h0);
      load(1'b1, 2'(r), (r == 0) ? 16'h0100 : 16'h0, (r == 1) ? 16'h0100 : 16'h0,
                        (r == 2) ? 16'h0100 : 16'h0, (r == 3) ? 16'h0100 : 16'h0);
    end
    launch(1'b0);
    chk("id c1 clear", 32'(array_clear), 32'd1);
    chk("id c1 busy",  32'(busy),        32'd1);
    adv_to(2);
    chk("id c2 a_row0", 32'(a_row0), 32'd1);
    chk("id c2 b_col0", 32'(b_col0), 32'd1);
    chk("id c2 a_row1", 32'(a_row1), 32'd0);
    chk("id c2 fv",     32'(feed_valid), 32'd1);
    adv_to(4);
    chk("id c4 a_row1", 32'(a_row1), 32'd1);
    chk("id c4 b_col1", 32'(b_col1), 32'd1);
    adv_to(8);
    chk("id c8 a_row3", 32'(a_row3), 32'd1);
    chk("id c8 b_col3", 32'(b_col3), 32'd1);
    chk("id c8 fv",     32'(feed_valid), 32'd1);
    adv_to(9);
    chk("id c9 fv", 32'(feed_valid), 32'd0);
    adv_to(13);
    chk("id c13 clear", 32'(array_clear), 32'd1);
    chk("id c13 pass",  32'(pass_id),     32'd1);
    adv_to(25);
    chk("id c25 clear", 32'(array_clear), 32'd1);
    chk("id c25 pass",  32'(pass_id),     32'd2);
    adv_to(37);
    chk("id c37 en",   32'(add_enable),   32'd1);
    chk("id c37 flag", 32'(add_int_flag), 32'd0);
    adv_to(38);
    chk("id c38 en",   32'(add_enable),   32'd1);
    chk("id c38 flag", 32'(add_int_flag), 32'd1);
    adv_to(39);
    chk("id c39 done", 32'(done), 32'd1);
    adv_to(40);
    chk("id c40 done", 32'(done), 32'd0);
    chk("id c40 busy", 32'(busy), 32'd0);

    // Split values plus a locked-out load and start during the run.
    load(1'b0, 2'd0, 16'h0180, 16'h0, 16'h0, 16'h0);
    load(1'b1, 2'd0, 16'hFF80, 16'h0, 16'h0, 16'h0);
    launch(1'b0);
    adv_to(2);
    chk("sp c2 a_row0", 32'(a_row0), 32'h001);
    chk("sp c2 b_col0", 32'(b_col0), 32'h1FF);
    adv_to(3);
    load_valid = 1'b1; load_sel = 1'b0; load_row = 2'd0;
    load_d0 = 16'h7FFF; load_d1 = 16'h7FFF; load_d2 = 16'h7FFF; load_d3 = 16'h7FFF;
    adv_to(4);
    load_valid = 1'b0;
    adv_to(10);
    start = 1'b1;
    adv_to(11);
    start = 1'b0;
    adv_to(14);
    chk("sp c14 a_row0", 32'(a_row0), 32'h001);
    chk("sp c14 b_col0", 32'(b_col0), 32'h080);
    adv_to(26);
    chk("sp c26 a_row0", 32'(a_row0), 32'h080);
    chk("sp c26 b_col0", 32'(b_col0), 32'h1FF);
    adv_to(39);
    chk("sp c39 done", 32'(done), 32'd1);
    adv_to(45);
    chk("lock no restart", 32'(busy), 32'd0);
    launch(1'b0);
    adv_to(2);
    chk("lock a_row0 kept", 32'(a_row0), 32'h001);
    chk("lock b_col0 kept", 32'(b_col0), 32'h1FF);
    adv_to(40);

    // Reset in the middle of FEED of pass 1.
    launch(1'b0);
    adv_to(15);
    chk("rs c15 fv",   32'(feed_valid), 32'd1);
    chk("rs c15 pass", 32'(pass_id),    32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rs async busy", 32'(busy),       32'd0);
    chk("rs async fv",   32'(feed_valid), 32'd0);
    chk("rs async pass", 32'(pass_id),    32'd0);
    chk("rs async a0",   32'(a_row0),     32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rs released busy", 32'(busy), 32'd0);
    launch(1'b0);
    adv_to(39);
    chk("rs c39 done", 32'(done), 32'd1);
    adv_to(40);

    // Varied tiles, start held high: two sequences back to back.
    for (int r = 0; r < 4; r++) begin
      load(1'b0, 2'(r),
           16'((((240 + r*4 + 0) % 256) * 256) + ((r*40 + 0*13 + 5) % 256)),
           16'((((240 + r*4 + 1) % 256) * 256) + ((r*40 + 1*13 + 5) % 256)),
           16'((((240 + r*4 + 2) % 256) * 256) + ((r*40 + 2*13 + 5) % 256)),
           16'((((240 + r*4 + 3) % 256) * 256) + ((r*40 + 3*13 + 5) % 256)));
      load(1'b1, 2'(r),
           16'((((r*3 + 0*5 + 250) % 256) * 256) + ((r*17 + 0*29 + 128) % 256)),
           16'((((r*3 + 1*5 + 250) % 256) * 256) + ((r*17 + 1*29 + 128) % 256)),
           16'((((r*3 + 2*5 + 250) % 256) * 256) + ((r*17 + 2*29 + 128) % 256)),
           16'((((r*3 + 3*5 + 250) % 256) * 256) + ((r*17 + 3*29 + 128) % 256)));
    end
    launch(1'b1);
    adv_to(2);
    chk("bb c2 a_row0", 32'(a_row0), 32'h1F0);
    chk("bb c2 b_col0", 32'(b_col0), 32'h1FA);
    adv_to(39);
    chk("bb c39 done", 32'(done), 32'd1);
    adv_to(40);
    chk("bb c40 busy", 32'(busy), 32'd0);
    adv_to(41);
    chk("bb c41 clear", 32'(array_clear), 32'd1);
    adv_to(42);
    chk("bb c42 a_row0", 32'(a_row0), 32'h1F0);
    adv_to(79);
    chk("bb c79 done", 32'(done), 32'd1);
    start = 1'b0;
    adv_to(81);
    chk("bb c81 busy", 32'(busy), 32'd0);
    adv_to(84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
